systolic_drain: RTL and testbench
=================================

Name: systolic_drain

Overview:
- Output-side collector for the weight-stationary systolic array of proc_elem tiles.
- Captures the skewed out_sum stream from the bottom row: column c's result arrives c cycles after column 0's.
- Deskews the columns into aligned result rows and buffers them in a small FIFO.
- Presents rows to the downstream consumer over a valid/ready handshake, with sticky error flags for skew faults and overflow.

Parameters:
- DATA_WIDTH, 4: operand width of array PEs.
- SUM_WIDTH, DATA_WIDTH*DATA_WIDTH: width of one partial-sum/result lane; must match PE out_sum width.
- COLS, 4: number of array columns (lanes per row).
- DEPTH, 4: FIFO depth in rows; power of two, ≥2.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of delay lines and FIFO; error flags unaffected.
- in_sum  input  COLS*SUM_WIDTH  bottom-row sums; lane c = bits [c*SUM_WIDTH +: SUM_WIDTH], signed.
- in_valid  input  COLS  per-lane valid; bit c qualifies lane c.
- out_row  output  COLS*SUM_WIDTH  FIFO head row, same lane packing.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts out_row this cycle.
- level  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
- skew_err  output  1  sticky: misaligned lane valids detected.
- overflow  output  1  sticky: aligned row dropped because FIFO full.

Behaviour:
- Reset (reset=0, async):
  - All delay-line stages and FIFO pointers cleared.
  - out_valid=0, level=0, skew_err=0, overflow=0.
  - out_row=0 (memory contents not reset; out_row gated to 0 when empty).
- Deskew:
  - Lane c passes through exactly COLS-c register stages (value plus valid); every lane has ≥1 stage.
  - Lane c sampled at edge t0+c reaches its last stage at edge t0+COLS-1 for every c.
  - Stages shift every cycle unconditionally; no backpressure into the array.
- Alignment check on last-stage valids, vector V:
  - V all ones: row write request.
  - V all zeros: idle.
  - Any other pattern: no write; skew_err set next edge and held until reset.
- FIFO write (at edge after alignment):
  - Accepted if level<DEPTH, or if level==DEPTH and a read occurs in the same cycle.
  - Otherwise the row is dropped and overflow is set (sticky).
- FIFO read:
  - Show-ahead: out_row is the oldest entry whenever out_valid=1.
  - Pop on out_valid && out_ready; out_ready while empty has no effect.
- Simultaneous write and read: level unchanged, both pointers advance.
- Pointers wrap modulo DEPTH; level distinguishes full from empty.
- Latency: out_valid rises COLS cycles after the edge that samples lane 0, i.e. edge t0+COLS when the FIFO was empty.
- Throughput: one row per cycle sustained when out_ready is held high.
- flush=1:
  - Next edge clears stage valids, pointers and level; out_valid=0.
  - In-flight partial rows are discarded.
  - skew_err and overflow are held.
  - flush takes priority over a same-cycle write or read.
- Reset asserted mid-operation: immediate clear per reset rules; no row is emitted after release until new lane-0 data enters.
- Arithmetic: none; lanes are transported bit-exact, sign preserved.

Test Plan:
1. Reset, then skewed row lanes {0x0001, 0x0002, 0x0003, 0x0004} at t0..t0+3, out_ready=1 -> out_valid high at edge t0+4, out_row lane c = c+1, level returns to 0 next cycle.
2. Four back-to-back skewed rows with values 10*r+c, out_ready=0 -> level=4, rows popped in order r=0..3 when out_ready=1, overflow=0.
3. FIFO full (level=4), fifth row aligns while out_ready=0 -> row dropped, overflow=1, level=4. Repeat with out_ready=1 in that cycle -> row accepted, level stays 4, overflow unchanged.
4. Lane 2 valid asserted one cycle late (V=4'b1011 at alignment) -> no write, skew_err=1 and remaining 1 after subsequent clean rows, which are still delivered.
5. Negative lanes {-1, -8, 0x7FFF, 0x8000} -> delivered bit-exact on out_row.
6. flush asserted with 2 rows queued and 1 row mid-skew -> level=0 and out_valid=0 next cycle, no row emitted afterward, error flags unchanged. reset pulsed low mid-skew -> all outputs 0 immediately.

Source files
------------

// File: rtl/systolic_drain.sv
// systolic_drain
// Output-side collector for a weight-stationary systolic array. The bottom
// row delivers lane c one cycle later than lane c-1; this block realigns the
// lanes into whole result rows, queues them in a small show-ahead FIFO and
// hands them to the consumer over a valid/ready handshake.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   flush      synchronous clear of delay lines and FIFO (error flags kept)
//   in_sum     bottom-row sums, lane c at [c*SUM_WIDTH +: SUM_WIDTH]
//   in_valid   per-lane valid
//   out_row    FIFO head row (zero while empty), same lane packing
//   out_valid  FIFO non-empty
//   out_ready  consumer accepts out_row this cycle
//   level      FIFO occupancy, 0..DEPTH
//   skew_err   sticky: lane valids arrived misaligned
//   overflow   sticky: aligned row dropped because the FIFO was full
module systolic_drain #(
    parameter int DATA_WIDTH = 4,
    parameter int SUM_WIDTH  = DATA_WIDTH * DATA_WIDTH,
    parameter int COLS       = 4,
    parameter int DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [COLS*SUM_WIDTH-1:0] in_sum,
    input  logic [COLS-1:0]           in_valid,
    output logic [COLS*SUM_WIDTH-1:0] out_row,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      skew_err,
    output logic                      overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int RW = COLS * SUM_WIDTH;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [RW-1:0]   last_row;
    logic [COLS-1:0] last_vld;

    // Lane c gets COLS-c stages so that every lane of one row lands in its
    // last stage on the same edge.
    for (genvar c = 0; c < COLS; c++) begin : g_lane
        localparam int NST = COLS - c;

        logic [SUM_WIDTH-1:0] val_q [NST];
        logic [SUM_WIDTH-1:0] val_d [NST];
        logic [NST-1:0]       vld_q;
        logic [NST-1:0]       vld_d;

        always_comb begin
            val_d[0] = in_sum[c*SUM_WIDTH +: SUM_WIDTH];
            vld_d    = '0;
            vld_d[0] = in_valid[c];
            for (int s = 1; s < NST; s++) begin
                val_d[s] = val_q[s-1];
                vld_d[s] = vld_q[s-1];
            end
            if (flush) begin
                vld_d = '0;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int s = 0; s < NST; s++) begin
                    val_q[s] <= '0;
                end
                vld_q <= '0;
            end else begin
                for (int s = 0; s < NST; s++) begin
                    val_q[s] <= val_d[s];
                end
                vld_q <= vld_d;
            end
        end

        assign last_row[c*SUM_WIDTH +: SUM_WIDTH] = val_q[NST-1];
        assign last_vld[c]                        = vld_q[NST-1];
    end

    logic [RW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          skew_err_q, skew_err_d;
    logic          overflow_q, overflow_d;
    logic          row_full, row_skew, do_wr, do_rd;

    assign out_valid = (level_q != '0);
    assign out_row   = out_valid ? mem_q[rd_ptr_q] : '0;
    assign level     = level_q;
    assign skew_err  = skew_err_q;
    assign overflow  = overflow_q;

    always_comb begin
        row_full = &last_vld;
        row_skew = (|last_vld) && !row_full;
        do_rd    = out_valid && out_ready && !flush;
        // A full FIFO still takes the row when the head leaves this cycle.
        do_wr    = row_full && !flush && ((level_q != FULL_LVL) || do_rd);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end

        skew_err_d = skew_err_q | row_skew;
        overflow_d = overflow_q | (row_full && !flush && !do_wr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            skew_err_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            skew_err_q <= skew_err_d;
            overflow_q <= overflow_d;
        end
    end

    // Row storage is not reset; out_row is gated while empty instead.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= last_row;
        end
    end

endmodule

// File: tb/tb_systolic_drain.sv
module tb_systolic_drain;

    localparam int COLS = 4;
    localparam int SW   = 16;
    localparam int RW   = COLS * SW;

    logic          clk;
    logic          reset;
    logic          flush;
    logic [RW-1:0] in_sum;
    logic [COLS-1:0] in_valid;
    logic [RW-1:0] out_row;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    level;
    logic          skew_err;
    logic          overflow;

    systolic_drain dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_sum    (in_sum),
        .in_valid  (in_valid),
        .out_row   (out_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .skew_err  (skew_err),
        .overflow  (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [RW-1:0] exp_q [$];
    logic [RW-1:0] rows_buf [8];

    task automatic chk(input string name, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    endtask

    // Scoreboard monitor: compares the head row on every accepted pop.
    initial begin
        logic [RW-1:0] e;
        forever begin
            @(negedge clk);
            if (reset && !flush && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_row got=%0h exp=none", out_row);
                end else begin
                    e = exp_q.pop_front();
                    chk("row", out_row, e);
                end
            end
        end
    end

    // Drives rows_buf[0..n-1] as skewed rows; optional lane delayed by late_dly.
    task automatic burst(input int n, input bit push, input int late_lane, input int late_dly);
        if (push) for (int r = 0; r < n; r++) exp_q.push_back(rows_buf[r]);
        for (int k = 0; k < n + COLS - 1 + late_dly; k++) begin
            @(posedge clk); #1;
            in_valid = '0;
            in_sum   = '0;
            for (int c = 0; c < COLS; c++) begin
                int r;
                r = k - c - ((c == late_lane) ? late_dly : 0);
                if (r >= 0 && r < n) begin
                    in_valid[c]       = 1'b1;
                    in_sum[c*SW +: SW] = rows_buf[r][c*SW +: SW];
                end
            end
        end
        @(posedge clk); #1;
        in_valid = '0;
        in_sum   = '0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
        @(posedge clk); #1;
        chk("drain_left", RW'(exp_q.size()), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_valid = '0; in_sum = '0;
        #22;
        chk("rst_valid", RW'(out_valid), '0);
        chk("rst_level", RW'(level), '0);
        chk("rst_skew", RW'(skew_err), '0);
        chk("rst_ovf", RW'(overflow), '0);
        chk("rst_row", out_row, '0);
        #1 reset = 1'b1;

        // 1: single row, latency
        out_ready = 1'b1;
        rows_buf[0] = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        burst(1, 1'b1, -1, 0);
        chk("lat_early", RW'(out_valid), '0);
        @(posedge clk); #1;
        chk("lat_valid", RW'(out_valid), 1);
        chk("lat_level", RW'(level), 1);
        @(posedge clk); #1;
        chk("t1_level0", RW'(level), '0);

        // 2: four back-to-back rows held, then drained in order
        out_ready = 1'b0;
        rows_buf[0] = {16'd3, 16'd2, 16'd1, 16'd0};
        rows_buf[1] = {16'd13, 16'd12, 16'd11, 16'd10};
        rows_buf[2] = {16'd23, 16'd22, 16'd21, 16'd20};
        rows_buf[3] = {16'd33, 16'd32, 16'd31, 16'd30};
        burst(4, 1'b1, -1, 0);
        repeat (2) @(posedge clk); #1;
        chk("t2_level4", RW'(level), 4);
        chk("t2_ovf", RW'(overflow), '0);
        out_ready = 1'b1;
        drain();
        chk("t2_level0", RW'(level), '0);

        // 3: overflow drop, then full-with-read acceptance
        out_ready = 1'b0;
        rows_buf[0] = {16'h0103, 16'h0102, 16'h0101, 16'h0100};
        rows_buf[1] = {16'h0113, 16'h0112, 16'h0111, 16'h0110};
        rows_buf[2] = {16'h0123, 16'h0122, 16'h0121, 16'h0120};
        rows_buf[3] = {16'h0133, 16'h0132, 16'h0131, 16'h0130};
        burst(4, 1'b1, -1, 0);
        repeat (2) @(posedge clk); #1;
        chk("t3_full", RW'(level), 4);
        chk("t3_ovf_pre", RW'(overflow), '0);
        rows_buf[0] = {16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD};
        burst(1, 1'b0, -1, 0);
        repeat (2) @(posedge clk); #1;
        chk("t3_ovf_set", RW'(overflow), 1);
        chk("t3_level_drop", RW'(level), 4);
        rows_buf[0] = {16'h0603, 16'h0602, 16'h0601, 16'h0600};
        burst(1, 1'b1, -1, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("t3_level_rw", RW'(level), 4);
        chk("t3_ovf_hold", RW'(overflow), 1);
        chk("t3_skew0", RW'(skew_err), '0);
        out_ready = 1'b1;
        drain();

        // 4: lane 2 one cycle late
        rows_buf[0] = {16'h0444, 16'h0333, 16'h0222, 16'h0111};
        burst(1, 1'b0, 2, 1);
        repeat (2) @(posedge clk); #1;
        chk("t4_skew", RW'(skew_err), 1);
        chk("t4_level", RW'(level), '0);
        rows_buf[0] = {16'h0A03, 16'h0A02, 16'h0A01, 16'h0A00};
        rows_buf[1] = {16'h0B03, 16'h0B02, 16'h0B01, 16'h0B00};
        burst(2, 1'b1, -1, 0);
        drain();
        chk("t4_skew_hold", RW'(skew_err), 1);

        // 5: signed lanes bit-exact
        rows_buf[0] = {16'h8000, 16'h7FFF, 16'hFFF8, 16'hFFFF};
        burst(1, 1'b1, -1, 0);
        drain();

        // 6a: flush with two queued rows and one partial row
        out_ready = 1'b0;
        rows_buf[0] = {16'h0C03, 16'h0C02, 16'h0C01, 16'h0C00};
        rows_buf[1] = {16'h0D03, 16'h0D02, 16'h0D01, 16'h0D00};
        burst(2, 1'b0, -1, 0);
        repeat (2) @(posedge clk); #1;
        chk("t6_level2", RW'(level), 2);
        in_valid = 4'b0001; in_sum = '0; in_sum[15:0] = 16'h0055;
        @(posedge clk); #1;
        in_valid = 4'b0010; in_sum = '0; in_sum[31:16] = 16'h0066;
        @(posedge clk); #1;
        in_valid = '0; in_sum = '0; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("t6_flush_level", RW'(level), '0);
        chk("t6_flush_valid", RW'(out_valid), '0);
        chk("t6_flush_row", out_row, '0);
        chk("t6_flush_skew", RW'(skew_err), 1);
        chk("t6_flush_ovf", RW'(overflow), 1);
        out_ready = 1'b1;
        repeat (8) @(posedge clk); #1;
        chk("t6_quiet_level", RW'(level), '0);

        // 6b: reset mid-skew with a row queued
        out_ready = 1'b0;
        rows_buf[0] = {16'h0E03, 16'h0E02, 16'h0E01, 16'h0E00};
        burst(1, 1'b0, -1, 0);
        @(posedge clk); #1;
        chk("t6_pre_rst_valid", RW'(out_valid), 1);
        in_valid = 4'b0001; in_sum = '0; in_sum[15:0] = 16'h0077;
        @(posedge clk); #1;
        in_valid = 4'b0010; in_sum = '0; in_sum[31:16] = 16'h0088;
        #2 reset = 1'b0;
        #1;
        chk("t6_rst_valid", RW'(out_valid), '0);
        chk("t6_rst_level", RW'(level), '0);
        chk("t6_rst_row", out_row, '0);
        chk("t6_rst_skew", RW'(skew_err), '0);
        chk("t6_rst_ovf", RW'(overflow), '0);
        in_valid = '0; in_sum = '0;
        repeat (2) @(posedge clk); #1;
        reset = 1'b1;
        out_ready = 1'b1;
        repeat (8) @(posedge clk); #1;
        chk("t6_post_rst_level", RW'(level), '0);
        chk("t6_post_rst_valid", RW'(out_valid), '0);

        rows_buf[0] = {16'h0F03, 16'h0F02, 16'h0F01, 16'h0F00};
        burst(1, 1'b1, -1, 0);
        drain();
        chk("final_level", RW'(level), '0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
